// File: rtl/bus_sequencer.sv
// Purpose: nibble-serial bus cycle sequencer (A1-A3 address, M1-M2 opcode fetch, X1-X3 execute).
// Latency: one state per clock; opr/opa/x_data update on the edge leaving M1, the last M2/WAIT, and X2.
// Backpressure: hold sampled only in X3/IDLE parks the sequencer in IDLE; other states ignore it.
//
// Ports:
//   clock, reset (async active-low)         : timing and reset
//   pc[11:0]                                : fetch address, registered on entry to A1
//   hold, long_instr, cpu_drive, cpu_data   : stall request, two-word flag, CPU bus drive in X2/X3
//   data_in / data_out / data_oe            : shared 4-bit bus
//   sync, phase[2:0]                        : cycle-start marker and current phase number
//   opr, opa, x_data                        : latched opcode nibbles and X2 bus capture
//   instr_valid, word2_valid, pc_inc        : single-cycle strobes
//
// Build option: define BUS_SEQ_WAIT_STATE_EN to insert WAIT_STATES extra M2 cycles;
// without it WAIT does not exist and WAIT_STATES has no effect.
module bus_sequencer #(
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] pc,
  input  logic        hold,
  input  logic        long_instr,
  input  logic        cpu_drive,
  input  logic [3:0]  cpu_data,
  input  logic [3:0]  data_in,
  output logic [3:0]  data_out,
  output logic        data_oe,
  output logic        sync,
  output logic [2:0]  phase,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic [3:0]  x_data,
  output logic        instr_valid,
  output logic        word2_valid,
  output logic        pc_inc
);

`ifdef BUS_SEQ_WAIT_STATE_EN
  typedef enum logic [3:0] {
    S_IDLE, S_A1, S_A2, S_A3, S_M1, S_M2, S_WAIT, S_X1, S_X2, S_X3
  } state_t;

  // Counter holds the number of WAIT cycles still to go after the current one.
  localparam logic [1:0] WAIT_CNT_INIT = 2'(WAIT_STATES - 1);
  logic [1:0] wait_cnt_q, wait_cnt_d;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2, S_X3
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [3:0]  opr_q, opr_d;
  logic [3:0]  opa_q, opa_d;
  logic [3:0]  x_data_q, x_data_d;
  logic        second_q, second_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      opr_q    <= '0;
      opa_q    <= '0;
      x_data_q <= '0;
      second_q <= 1'b0;
`ifdef BUS_SEQ_WAIT_STATE_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opr_q    <= opr_d;
      opa_q    <= opa_d;
      x_data_q <= x_data_d;
      second_q <= second_d;
`ifdef BUS_SEQ_WAIT_STATE_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opr_d    = opr_q;
    opa_d    = opa_q;
    x_data_d = x_data_q;
    second_d = second_q;
`ifdef BUS_SEQ_WAIT_STATE_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_X3: begin
        if (hold) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_A1;
          pc_d    = pc;
        end
      end
      S_A1: state_d = S_A2;
      S_A2: state_d = S_A3;
      S_A3: state_d = S_M1;
      S_M1: begin
        state_d = S_M2;
        opr_d   = data_in;
      end
      S_M2: begin
`ifdef BUS_SEQ_WAIT_STATE_EN
        if (WAIT_STATES > 0) begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_CNT_INIT;
        end else begin
          state_d = S_X1;
          opa_d   = data_in;
        end
`else
        state_d = S_X1;
        opa_d   = data_in;
`endif
      end
`ifdef BUS_SEQ_WAIT_STATE_EN
      S_WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          state_d = S_X1;
          opa_d   = data_in;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
`endif
      S_X1: begin
        state_d = S_X2;
        // A second-word fetch always clears the flag; long_instr only matters on a first word.
        second_d = second_q ? 1'b0 : long_instr;
      end
      S_X2: begin
        state_d = S_X3;
        if (!cpu_drive) x_data_d = data_in;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from the state register only, so reset clears them without a clock.
  always_comb begin
    data_out    = 4'h0;
    data_oe     = 1'b0;
    sync        = 1'b0;
    phase       = 3'd7;
    instr_valid = 1'b0;
    word2_valid = 1'b0;
    pc_inc      = 1'b0;
    case (state_q)
      S_A1: begin phase = 3'd0; data_oe = 1'b1; data_out = pc_q[3:0]; end
      S_A2: begin phase = 3'd1; data_oe = 1'b1; data_out = pc_q[7:4]; end
      S_A3: begin phase = 3'd2; data_oe = 1'b1; data_out = pc_q[11:8]; pc_inc = 1'b1; end
      S_M1: phase = 3'd3;
      S_M2: phase = 3'd4;
`ifdef BUS_SEQ_WAIT_STATE_EN
      S_WAIT: phase = 3'd4;
`endif
      S_X1: begin
        phase       = 3'd5;
        instr_valid = ~second_q;
        word2_valid = second_q;
      end
      S_X2: begin phase = 3'd6; data_oe = cpu_drive; data_out = cpu_data; end
      S_X3: begin phase = 3'd7; data_oe = cpu_drive; data_out = cpu_data; sync = 1'b1; end
      default: begin phase = 3'd7; sync = 1'b1; end
    endcase
  end

  assign opr    = opr_q;
  assign opa    = opa_q;
  assign x_data = x_data_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Purpose: self-checking bench for bus_sequencer against a position-in-cycle reference model.
// Latency: model advances once per rising edge; outputs compared 1 time unit after each falling edge.
// Backpressure: hold stimulus exercises X3/IDLE stalls and ignored hold pulses elsewhere.
module tb_bus_sequencer;

  localparam int WS = 2;
`ifdef BUS_SEQ_WAIT_STATE_EN
  localparam int EW = WS;
`else
  localparam int EW = 0;
`endif
  // Bus cycle length in clocks: A1 A2 A3 M1 M2 [WAIT x EW] X1 X2 X3
  localparam int N = 8 + EW;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] pc = '0;
  logic        hold = 1'b0;
  logic        long_instr = 1'b0;
  logic        cpu_drive = 1'b0;
  logic [3:0]  cpu_data = '0;
  logic [3:0]  data_in = '0;
  logic [3:0]  data_out;
  logic        data_oe;
  logic        sync;
  logic [2:0]  phase;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [3:0]  x_data;
  logic        instr_valid;
  logic        word2_valid;
  logic        pc_inc;

  bus_sequencer #(.WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .pc(pc), .hold(hold), .long_instr(long_instr),
    .cpu_drive(cpu_drive), .cpu_data(cpu_data), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .sync(sync), .phase(phase),
    .opr(opr), .opa(opa), .x_data(x_data),
    .instr_valid(instr_valid), .word2_valid(word2_valid), .pc_inc(pc_inc)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: idle flag or the clock index within the current bus cycle.
  bit          m_idle;
  int          m_pos;
  logic [11:0] m_pc;
  logic [3:0]  m_opr, m_opa, m_x;
  bit          m_second;

  task automatic model_reset();
    m_idle = 1'b1; m_pos = 0; m_pc = '0;
    m_opr = '0; m_opa = '0; m_x = '0; m_second = 1'b0;
  endtask

  function automatic int m_phase();
    if (m_idle)         return 7;
    if (m_pos < 5)      return m_pos;
    if (m_pos < 5 + EW) return 4;
    return m_pos - EW;
  endfunction

  task automatic check_outputs();
    int   ph;
    bit   addr, xdrv;
    logic [3:0] e_out;
    logic e_oe;
    ph   = m_phase();
    addr = !m_idle && (m_pos < 3);
    xdrv = !m_idle && (ph == 6 || ph == 7);
    e_oe  = addr ? 1'b1 : (xdrv ? cpu_drive : 1'b0);
    e_out = addr ? 4'((m_pc >> (4 * m_pos)) & 12'hF) : (xdrv ? cpu_data : 4'h0);
    check("phase", 16'(phase), 16'(ph));
    check("sync", 16'(sync), 16'(m_idle || ph == 7));
    check("data_oe", 16'(data_oe), 16'(e_oe));
    check("data_out", 16'(data_out), 16'(e_out));
    check("pc_inc", 16'(pc_inc), 16'(!m_idle && m_pos == 2));
    check("instr_valid", 16'(instr_valid), 16'(!m_idle && ph == 5 && !m_second));
    check("word2_valid", 16'(word2_valid), 16'(!m_idle && ph == 5 && m_second));
    check("opr", 16'(opr), 16'(m_opr));
    check("opa", 16'(opa), 16'(m_opa));
    check("x_data", 16'(x_data), 16'(m_x));
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_step();
    if (m_idle || m_pos == N - 1) begin
      if (hold) begin
        m_idle = 1'b1;
      end else begin
        m_idle = 1'b0; m_pos = 0; m_pc = pc;
      end
    end else begin
      if (m_pos == 3)      m_opr = data_in;
      if (m_pos == 4 + EW) m_opa = data_in;
      if (m_pos == 5 + EW) m_second = m_second ? 1'b0 : long_instr;
      if (m_pos == 6 + EW && !cpu_drive) m_x = data_in;
      m_pos++;
    end
  endtask

  // Called at a falling edge: drive, compare, advance model, then wait one full clock.
  task automatic cycle(input logic [11:0] p, input bit h, input bit l, input bit d,
                       input logic [3:0] cd, input logic [3:0] di);
    pc = p; hold = h; long_instr = l; cpu_drive = d; cpu_data = cd; data_in = di;
    #1;
    check_outputs();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [3:0] fetch_din();
    if (!m_idle && m_pos == 3) return 4'h2;
    if (!m_idle && m_pos >= 4 && m_pos <= 4 + EW) return 4'hD;
    return 4'($urandom);
  endfunction

  task automatic run_to(input int target);
    for (int k = 0; k < 4 * N && (m_idle || m_pos != target); k++)
      cycle(12'hABC, 1'b0, 1'b0, 1'b0, 4'h0, 4'($urandom));
    check("run_to_reached", 16'(m_idle ? -1 : m_pos), 16'(target));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_phase"}, 16'(phase), 16'd7);
    check({tag, "_sync"}, 16'(sync), 16'd1);
    check({tag, "_oe"}, 16'(data_oe), 16'd0);
    check({tag, "_out"}, 16'(data_out), 16'd0);
    check({tag, "_opr"}, 16'(opr), 16'd0);
    check({tag, "_opa"}, 16'(opa), 16'd0);
    check({tag, "_xdata"}, 16'(x_data), 16'd0);
    check({tag, "_strobes"}, 16'({instr_valid, word2_valid, pc_inc}), 16'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_reset_state("reset");
    @(negedge clock);
    reset = 1'b1;

    // Plain fetch of 0xABC with opcode 0x2D
    for (int i = 0; i < N; i++)
      cycle(12'hABC, 1'b0, 1'b0, 1'b0, 4'h0, fetch_din());
    check("opr_fetch", 16'(opr), 16'h2);
    check("opa_fetch", 16'(opa), 16'hD);

    // Two-word instruction; long_instr stays high through the second word
    for (int i = 0; i < N; i++) cycle(12'h123, 1'b0, 1'b1, 1'b0, 4'h0, 4'($urandom));
    for (int i = 0; i < N; i++) cycle(12'h124, 1'b0, 1'b1, 1'b0, 4'h0, 4'($urandom));
    for (int i = 0; i < N; i++) cycle(12'h125, 1'b0, 1'b0, 1'b0, 4'h0, 4'($urandom));

    // Long instruction, then hold for 5 clocks at X3; second word follows the stall
    for (int i = 0; i < N; i++) cycle(12'h300, 1'b0, 1'b1, 1'b0, 4'h0, 4'($urandom));
    run_to(N - 1);
    for (int i = 0; i < 5; i++) cycle(12'h301, 1'b1, 1'b0, 1'b0, 4'h0, 4'($urandom));
    for (int i = 0; i < N; i++) cycle(12'h301, 1'b0, 1'b0, 1'b0, 4'h0, 4'($urandom));

    // Hold pulsed in M1 is ignored
    for (int i = 0; i < N; i++)
      cycle(12'h456, (!m_idle && m_pos == 3), 1'b0, 1'b0, 4'h0, 4'($urandom));

    // CPU drives 0x5 in X2/X3: bus shows it, x_data keeps its value
    for (int i = 0; i < N; i++) cycle(12'h789, 1'b0, 1'b0, 1'b1, 4'h5, 4'($urandom));

    // Asynchronous reset in the middle of A2
    run_to(1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(12'($urandom), ($urandom_range(3) == 0), 1'($urandom), 1'($urandom),
            4'($urandom), 4'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
